// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC generation, one outstanding memory read, and a
// 2-entry {pc, instruction} buffer toward the decoder with redirect/flush.
module inst_fetch #(
  parameter int NADDR_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [NADDR_BITS-1:0] address,
  input  logic [31:0]           q,
  input  logic                  redirect,
  input  logic [NADDR_BITS-1:0] redirect_pc,
  output logic                  inst_valid,
  output logic [31:0]           inst,
  output logic [NADDR_BITS-1:0] inst_pc,
  input  logic                  inst_ready,
  output logic                  align_err
);

  logic [NADDR_BITS-1:0] pc_r, pc_n;
  logic                  inflight_r, inflight_n;
  logic [NADDR_BITS-1:0] tag_r, tag_n;
  logic [1:0]            count_r, count_n;
  logic [NADDR_BITS-1:0] ent_pc_r [2];
  logic [NADDR_BITS-1:0] ent_pc_n [2];
  logic [31:0]           ent_data_r [2];
  logic [31:0]           ent_data_n [2];
  logic                  valid_r, valid_n;
  logic                  align_r, align_n;

  logic                  pop_s;
  logic                  issue_s;
  logic                  capture_s;
  logic [2:0]            fill_s;
  logic [1:0]            wr_slot_s;
  logic                  wr_ok_s;

  // Handshake decode: pop, issue and capture for this edge
  always_comb begin
    pop_s     = (count_r != 2'd0) && inst_ready;
    fill_s    = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s   = !redirect && (fill_s < 3'd2);
    capture_s = inflight_r && !redirect;
    wr_slot_s = count_r - {1'b0, pop_s};
    wr_ok_s   = capture_s && (wr_slot_s < 2'd2);
  end

  // Next-state computation for PC, in-flight tracking and the head-at-0 buffer
  always_comb begin
    pc_n       = pc_r;
    inflight_n = 1'b0;
    tag_n      = tag_r;
    count_n    = count_r;
    ent_pc_n   = ent_pc_r;
    ent_data_n = ent_data_r;
    align_n    = align_r;
    if (redirect) begin
      // Flush drops any same-edge pop or capture
      pc_n    = {redirect_pc[NADDR_BITS-1:2], 2'b00};
      count_n = 2'd0;
      if (redirect_pc[1:0] != 2'b00) begin
        align_n = 1'b1;
      end else begin
        align_n = align_r;
      end
    end else begin
      if (issue_s) begin
        inflight_n = 1'b1;
        tag_n      = pc_r;
        pc_n       = pc_r + NADDR_BITS'(3'd4);
      end else begin
        inflight_n = 1'b0;
        pc_n       = pc_r;
      end
      if (pop_s) begin
        ent_pc_n[0]   = ent_pc_r[1];
        ent_data_n[0] = ent_data_r[1];
      end else begin
        ent_pc_n[0]   = ent_pc_r[0];
        ent_data_n[0] = ent_data_r[0];
      end
      if (wr_ok_s) begin
        case (wr_slot_s)
          2'd0: begin
            ent_pc_n[0]   = tag_r;
            ent_data_n[0] = q;
          end
          2'd1: begin
            ent_pc_n[1]   = tag_r;
            ent_data_n[1] = q;
          end
          default: begin
            ent_pc_n[1]   = ent_pc_r[1];
            ent_data_n[1] = ent_data_r[1];
          end
        endcase
        count_n = wr_slot_s + 2'd1;
      end else begin
        count_n = wr_slot_s;
      end
    end
    valid_n = (count_n != 2'd0);
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r       <= '0;
      inflight_r <= 1'b0;
      tag_r      <= '0;
      count_r    <= 2'd0;
      ent_pc_r   <= '{default: '0};
      ent_data_r <= '{default: 32'd0};
      valid_r    <= 1'b0;
      align_r    <= 1'b0;
    end else begin
      pc_r       <= pc_n;
      inflight_r <= inflight_n;
      tag_r      <= tag_n;
      count_r    <= count_n;
      ent_pc_r   <= ent_pc_n;
      ent_data_r <= ent_data_n;
      valid_r    <= valid_n;
      align_r    <= align_n;
    end
  end

  assign address    = pc_r;
  assign inst_valid = valid_r;
  assign inst       = ent_data_r[0];
  assign inst_pc    = ent_pc_r[0];
  assign align_err  = align_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized self-checking bench for inst_fetch against a queue-based
// transaction model plus directed scenarios with hand-computed expectations.
module tb_inst_fetch;

  localparam int NB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] address;
  logic [31:0]   q;
  logic          redirect;
  logic [NB-1:0] redirect_pc;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [NB-1:0] inst_pc;
  logic          inst_ready;
  logic          align_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: fetch pc, one outstanding read, queue of buffered pcs
  logic [NB-1:0] m_pc;
  bit            m_infl;
  logic [NB-1:0] m_tag;
  logic [NB-1:0] m_q[$];
  bit            m_align;

  inst_fetch #(.NADDR_BITS(NB)) dut (
    .clock(clock), .reset(reset), .address(address), .q(q),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .align_err(align_err)
  );

  always #5 clock = ~clock;

  // 1-cycle synchronous ROM: data[i] = 0xA0000000 + i
  always @(posedge clock) q <= 32'hA000_0000 + {26'd0, address[NB-1:2]};

  function automatic logic [31:0] rom(input logic [NB-1:0] a);
    return 32'hA000_0000 + 32'(a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs, then compare
  task automatic step();
    bit pop, issue;
    if (reset) begin
      m_pc = '0; m_infl = 1'b0; m_q.delete(); m_align = 1'b0;
    end else if (redirect) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc = redirect_pc & 8'hFC;
      if (redirect_pc[1:0] != 2'b00) m_align = 1'b1;
    end else begin
      pop   = (m_q.size() > 0) && inst_ready;
      issue = (m_q.size() + int'(m_infl) - int'(pop)) < 2;
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_tag);
      if (issue) begin
        m_infl = 1'b1; m_tag = m_pc; m_pc = m_pc + 8'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    chk("address", 32'(address), 32'(m_pc));
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
    chk("align_err", 32'(align_err), 32'(m_align));
    if (m_q.size() > 0) begin
      chk("inst_pc", 32'(inst_pc), 32'(m_q[0]));
      chk("inst", inst, rom(m_q[0]));
    end
    if (reset) begin
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", 32'(inst_pc), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    m_pc = '0; m_infl = 1'b0; m_tag = '0; m_align = 1'b0;
    step(); step();
    // Reset release: E1 issues 0, E2 shows it, E3 shows pc 4
    reset = 1'b0;
    step();
    chk("e1_valid", 32'(inst_valid), 32'd0);
    step();
    chk("e2_inst", inst, 32'hA000_0000);
    chk("e2_pc", 32'(inst_pc), 32'h00);
    step();
    chk("e3_inst", inst, 32'hA000_0001);
    chk("e3_pc", 32'(inst_pc), 32'h04);
    step();
    chk("head08", 32'(inst_pc), 32'h08);
    // Backpressure for 5 cycles with 0x08 at head
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_head", 32'(inst_pc), 32'h08);
    end
    inst_ready = 1'b1;
    step();
    chk("rel_0c", 32'(inst_pc), 32'h0C);
    step();
    chk("rel_10", 32'(inst_pc), 32'h10);
    // Redirect to 0x40 while streaming
    redirect = 1'b1; redirect_pc = 8'h40;
    step();
    chk("rd_v0", 32'(inst_valid), 32'd0);
    redirect = 1'b0;
    step();
    chk("rd_v1", 32'(inst_valid), 32'd0);
    step();
    chk("rd_inst", inst, 32'hA000_0010);
    chk("rd_pc", 32'(inst_pc), 32'h40);
    // Wrap-around from 0xF8
    redirect = 1'b1; redirect_pc = 8'hF8;
    step();
    redirect = 1'b0;
    step(); step();
    chk("wrap_f8", 32'(inst_pc), 32'hF8);
    step();
    chk("wrap_fc", 32'(inst_pc), 32'hFC);
    step();
    chk("wrap_00", 32'(inst_pc), 32'h00);
    step();
    chk("wrap_04", 32'(inst_pc), 32'h04);
    // Misaligned target, then an aligned one; flag must stick
    redirect = 1'b1; redirect_pc = 8'h22;
    step();
    chk("al_set", 32'(align_err), 32'd1);
    redirect = 1'b0;
    step(); step();
    chk("al_pc", 32'(inst_pc), 32'h20);
    redirect = 1'b1; redirect_pc = 8'h30;
    step();
    redirect_pc = 8'h50;
    step();
    redirect = 1'b0;
    step(); step();
    chk("b2b_pc", 32'(inst_pc), 32'h50);
    chk("al_stick", 32'(align_err), 32'd1);
    // One-cycle reset mid-stream
    reset = 1'b1;
    step();
    chk("mr_valid", 32'(inst_valid), 32'd0);
    chk("mr_align", 32'(align_err), 32'd0);
    reset = 1'b0;
    step();
    chk("mr_e1", 32'(inst_valid), 32'd0);
    step();
    chk("mr_e2", 32'(inst_pc), 32'h00);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      inst_ready  = ($urandom_range(0, 99) < 70);
      redirect    = ($urandom_range(0, 99) < 6);
      redirect_pc = NB'($urandom_range(0, 255));
      reset       = ($urandom_range(0, 99) < 2);
      step();
    end
    reset = 1'b0; redirect = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
